// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of UNROLL bits: shift-add multiply or restoring divide,
// chosen by mode_div_i. Multiply keeps {hi[XLEN-1:0], lo} as the product;
// divide keeps the partial remainder in hi and the quotient shifting into lo.
module muldiv_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            mode_div_i,
  input  logic [XLEN:0]   hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   h;
  logic [XLEN-1:0] l;
  logic [XLEN:0]   sum;
  logic [XLEN+1:0] sh;
  logic [XLEN+1:0] diff;

  always_comb begin
    h    = hi_i;
    l    = lo_i;
    sum  = '0;
    sh   = '0;
    diff = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (mode_div_i) begin
        // Extra headroom bit so the borrow of the trial subtraction is exact.
        sh   = {h, l[XLEN-1]};
        diff = sh - {2'b00, opnd_i};
        l    = {l[XLEN-2:0], ~diff[XLEN+1]};
        h    = diff[XLEN+1] ? sh[XLEN:0] : diff[XLEN:0];
      end else begin
        sum = h + {1'b0, (l[0] ? opnd_i : {XLEN{1'b0}})};
        l   = {sum[0], l[XLEN-1:1]};
        h   = {1'b0, sum[XLEN:1]};
      end
    end
    hi_o = h;
    lo_o = l;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
//   state | meaning
//   IDLE  | ready; accepts an op unless flushed
//   CALC  | UNROLL bits per cycle, counter N..1
//   FIX   | sign correction and result selection
//   DONE  | valid_o pulse, result committed
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            in_sa, in_sb, in_div, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic [XLEN:0]   step_hi;
  logic [XLEN-1:0] step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  assign in_sa    = a_signed(op_i) & a_i[XLEN-1];
  assign in_sb    = b_signed(op_i) & b_i[XLEN-1];
  assign in_div   = is_div(op_i);
  assign a_mag    = in_sa ? -a_i : a_i;
  assign b_mag    = in_sb ? -b_i : b_i;
  assign div_zero = in_div & (b_i == '0);
  assign div_ovf  = in_div & ~op_i[0] & (a_i == MIN_NEG) & (&b_i);
  // op[1] separates REM/REMU from DIV/DIVU.
  assign spec_res = op_i[1] ? (div_zero ? a_i : '0) : (div_zero ? '1 : MIN_NEG);

  muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .mode_div_i (is_div(op_q)),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .opnd_i     (opnd_q),
    .hi_o       (step_hi),
    .lo_o       (step_lo)
  );

  assign prod     = {hi_q[XLEN-1:0], lo_q};
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
  assign rem_fix  = sign_a_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          op_d     = op_i;
          rd_d     = rd_i;
          sign_a_d = in_sa;
          sign_b_d = in_sb;
          if (div_zero || div_ovf) begin
            result_d = spec_res;
            rd_out_d = rd_i;
            state_d  = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = in_div ? a_mag : b_mag;
            opnd_d  = in_div ? b_mag : a_mag;
            cnt_d   = CW'(N);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          result_d = fix_res;
          rd_out_d = rd_q;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an UNROLL=1 and an UNROLL=4 instance share
// the request inputs; expected results go through a scoreboard queue.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_i;

  logic        ready1, valid1, busy1;
  logic [31:0] res1;
  logic [4:0]  rd1;
  logic        ready4, valid4, busy4;
  logic [31:0] res4;
  logic [4:0]  rd4;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut1 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready1), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .rd_i(rd_i), .flush_i(flush_i), .valid_o(valid1),
    .result_o(res1), .rd_o(rd1), .busy_o(busy1)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready4), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .rd_i(rd_i), .flush_i(flush_i), .valid_o(valid4),
    .result_o(res4), .rd_o(rd4), .busy_o(busy4)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready1 && ready4) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", {63'd0, ready1 && ready4}, 64'd1);
  endtask

  // lat counts posedges from the accepting edge (inclusive) to the valid_o cycle.
  // poke > 0 drives a stray request in that cycle of the operation.
  task automatic run_op(input string name, input bit sel, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat, input int poke);
    exp_t e;
    int   cnt;
    bit   got;
    wait_ready();
    @(negedge clk);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
    @(posedge clk);
    sb.push_back('{exp, rd, lat});
    #1;
    valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 3'($urandom); rd_i = 5'($urandom);
    cnt = 1;
    got = 1'b0;
    while (!got && cnt <= 100) begin
      if (sel ? valid4 : valid1) begin
        got = 1'b1;
      end else begin
        if (cnt == poke) begin
          check({name, "_busy_ready"}, {63'd0, sel ? ready4 : ready1}, 64'd0);
          valid_i = 1'b1;
        end else begin
          valid_i = 1'b0;
        end
        @(posedge clk); #1; cnt++;
      end
    end
    valid_i = 1'b0;
    check({name, "_valid_seen"}, {63'd0, got}, 64'd1);
    e = sb.pop_front();
    if (got) begin
      check({name, "_result"}, sel ? res4 : res1, e.res);
      check({name, "_rd"}, sel ? rd4 : rd1, e.rd);
      check({name, "_latency"}, cnt, e.lat);
      @(posedge clk); #1;
      check({name, "_pulse_width"}, {63'd0, sel ? valid4 : valid1}, 64'd0);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
    #1;
    check("rst_ready1", ready1, 1);
    check("rst_busy1",  busy1,  0);
    check("rst_valid1", valid1, 0);
    check("rst_res1",   res1,   0);
    check("rst_rd1",    rd1,    0);
    check("rst_ready4", ready4, 1);
    check("rst_res4",   res4,   0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("mul",    0, OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34, 0);
    run_op("mulhu",  0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34, 0);
    run_op("mulhsu", 0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34, 0);
    run_op("div",    0, OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 34, 0);
    run_op("rem",    0, OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 34, 0);
    run_op("divu",   0, OP_DIVU,   32'd7,          32'd2,         5'd12, 32'd3,         34, 0);
    run_op("remu",   0, OP_REMU,   32'd7,          32'd2,         5'd13, 32'd1,         34, 0);

    run_op("div_by0",  0, OP_DIV,  32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0", 0, OP_REMU, 32'd5,          32'd0,         5'd15, 32'd5,         1, 0);
    run_op("div_ovf",  0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",  0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1, 0);

    // Flush in the 10th CALC cycle.
    wait_ready();
    @(negedge clk);
    valid_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; rd_i = 5'd9;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_ready", ready1, 1);
    check("flush_busy",  busy1,  0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid1) seen = 1'b1;
    end
    check("flush_no_valid", {63'd0, seen}, 64'd0);
    run_op("divu_after_flush", 0, OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 34, 0);

    // Request while busy must be ignored.
    run_op("mul_busy_poke", 0, OP_MUL, 32'd12345, 32'd678, 5'd3, 32'd8369910, 34, 6);

    // Asynchronous reset in the middle of CALC.
    wait_ready();
    @(negedge clk);
    valid_i = 1'b1; op_i = OP_MUL; a_i = 32'd3; b_i = 32'd4; rd_i = 5'd21;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_res",   res1,   0);
    check("arst_rd",    rd1,    0);
    check("arst_busy",  busy1,  0);
    check("arst_ready", ready1, 1);
    check("arst_valid", valid1, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid1) seen = 1'b1;
    end
    check("arst_no_valid", {63'd0, seen}, 64'd0);

    run_op("mul_u4",  1, OP_MUL,  32'd12345, 32'd678, 5'd30, 32'd8369910, 10, 0);
    run_op("divu_u4", 1, OP_DIVU, 32'd100,   32'd7,   5'd31, 32'd14,      10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
